filter_ctrl_slew: RTL and testbench
===================================

FILTER_CTRL_SLEW -- requirements
Module: filter_ctrl_slew

Interface
- REQ-001 Parameter W, default 16: sample and coefficient width in bits.
- REQ-002 Parameter SLEW_STEP, default 64: maximum per-sample change of either coefficient.
- REQ-003 Parameters F_MIN/F_MAX, defaults -31000/-1000: cutoff coefficient clamp bounds.
- REQ-004 Parameters Q_MIN/Q_MAX, defaults -32000/-8000: damping coefficient clamp bounds.
- REQ-005 Port clk, input, 1: single system clock; all logic is in this domain.
- REQ-006 Port rst, input, 1: synchronous, active-high reset.
- REQ-007 Port sample_clk, input, 1: sample strobe; it is sampled on clk.
- REQ-008 Port cv_cutoff, input, W signed: raw cutoff control voltage.
- REQ-009 Port cv_reso, input, W signed: raw resonance control voltage.
- REQ-010 Port F, output, W signed: slewed cutoff coefficient for the downstream state-variable filter.
- REQ-011 Port Q1, output, W signed: slewed damping coefficient.
- REQ-012 Port coeff_valid, output, 1: one-clk pulse when F and Q1 update.
- REQ-013 Port overrun, output, 1: sticky flag; set when a sample edge arrives while the block is busy.

Function
- REQ-014 The block shall register sample_clk and shall detect a rising edge on the cycle where the current sample is 1 and the previous sample was 0.
- REQ-015 State machine sequence: IDLE -> CAPTURE on an edge; then CAPTURE -> SLEW_F -> SLEW_Q -> COMMIT -> IDLE, one clk per state, unconditionally.
- REQ-016 CAPTURE shall latch cv_cutoff and cv_reso; input changes after CAPTURE shall not affect the current update.
- REQ-017 Cutoff target = clamp((-cv_cutoff >>> 1) - 15000, F_MIN, F_MAX).
- REQ-018 Cutoff target arithmetic shall be done at W+2 bits, so negating -32768 does not overflow.
- REQ-019 Resonance target = clamp(-32000 + (cv_reso >>> 2), Q_MIN, Q_MAX), computed at W+2 bits.
- REQ-020 SLEW_F shall set the next F: state + clamp(target - state, -SLEW_STEP, +SLEW_STEP). SLEW_Q shall do the same for Q1.
- REQ-021 COMMIT shall drive the new F and Q1 onto the outputs and assert coeff_valid for exactly that cycle.
- REQ-022 F and Q1 shall be stable between COMMITs.
- REQ-023 Latency: coeff_valid shall be high 4 clk after the edge-detect cycle.
- REQ-024 An edge detected in any state other than IDLE shall be dropped and shall set overrun.
- REQ-025 overrun shall clear only on reset.
- REQ-026 If the target equals the current state, the output shall not change, but coeff_valid shall still pulse.

Reset
- REQ-027 While rst is high: state = IDLE, F = -15000, Q1 = -32000, coeff_valid = 0, overrun = 0, edge-detect register = 0.
- REQ-028 Reset asserted mid-sequence shall abort the sequence with no coeff_valid pulse and no partial update.
- REQ-029 After reset, if sample_clk is already high, the first edge-detect cycle shall not register a rising edge.

Configuration
- REQ-030 Macro FILTER_CTRL_SLEW_EN defined: slew limiting per REQ-020.
- REQ-031 Macro undefined: SLEW_F and SLEW_Q shall load the clamped target directly. State sequence, latency and coeff_valid timing shall be unchanged.

Structure
- REQ-032 Package filter_ctrl_pkg shall hold the state enum (IDLE, CAPTURE, SLEW_F, SLEW_Q, COMMIT) and the reset constants F_RESET = -15000 and Q_RESET = -32000.
- REQ-033 Sub-module slew_limit: a combinational step-clamp of (state, target, step) to the next state, instanced once and time-shared between SLEW_F and SLEW_Q.

Verification
- REQ-034 Reset, then cv_cutoff = 0, cv_reso = 0, 10 edges -> F = -15000 and Q1 = -32000 throughout; 10 coeff_valid pulses.
- REQ-035 cv_cutoff = -20000 (target -5000), slew enabled -> F = -14936 after edge 1; F = -5000 first at edge 157 and held thereafter.
- REQ-036 cv_cutoff = -32768 and then 32767, macro undefined -> F = -1000, then F = -31000 (clamped), each updating at the next COMMIT.
- REQ-037 cv_reso = 8000 (target -30000) -> Q1 = -31936 after edge 1; cv_reso = -32768 -> Q1 stays at -32000 (clamped).
- REQ-038 Second edge 2 clk after the first -> overrun = 1 and exactly one coeff_valid pulse; overrun is still set 100 clk later.
- REQ-039 rst asserted in SLEW_Q -> no coeff_valid; F = -15000 and Q1 = -32000 on the next cycle.

Source files
------------

// File: rtl/filter_ctrl_pkg.sv
// rtl/filter_ctrl_pkg.sv - shared types and constants for the filter coefficient slew controller
// Purpose: sequencer state encoding plus reset and offset constants used by
//          filter_ctrl_slew.
// Contents: state_t (IDLE, CAPTURE, SLEW_F, SLEW_Q, COMMIT), F_RESET, Q_RESET,
//           CUT_OFFSET, RESO_BASE.
package filter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SLEW_F  = 3'd2,
        SLEW_Q  = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    localparam int F_RESET    = -15000;
    localparam int Q_RESET    = -32000;

    // Offsets applied to the scaled control voltages before clamping.
    localparam int CUT_OFFSET = -15000;
    localparam int RESO_BASE  = -32000;

endpackage

// File: rtl/filter_ctrl_slew_slew_limit.sv
// rtl/filter_ctrl_slew_slew_limit.sv - combinational step clamp toward a target
// Purpose: nxt = cur + clamp(target - cur, -step, +step), evaluated at W+2 bits
//          so the difference of two W-bit values never wraps.
// Ports:
//   cur    in  W signed    present coefficient
//   target in  W signed    coefficient being approached
//   step   in  W+2 signed  largest allowed change (positive)
//   nxt    out W signed    next coefficient
module slew_limit #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] cur,
    input  logic signed [W-1:0] target,
    input  logic signed [W+1:0] step,
    output logic signed [W-1:0] nxt
);

    logic signed [W+1:0] cur_x;
    logic signed [W+1:0] tgt_x;
    logic signed [W+1:0] diff;
    logic signed [W+1:0] delta;
    logic signed [W+1:0] sum;

    always_comb begin
        cur_x = {{2{cur[W-1]}}, cur};
        tgt_x = {{2{target[W-1]}}, target};
        diff  = tgt_x - cur_x;
        if (diff > step) begin
            delta = step;
        end else if (diff < -step) begin
            delta = -step;
        end else begin
            delta = diff;
        end
        // The sum lies between cur and target, so it always fits in W bits.
        sum = cur_x + delta;
        nxt = sum[W-1:0];
    end

endmodule

// File: rtl/filter_ctrl_slew.sv
// rtl/filter_ctrl_slew.sv - control-voltage to slewed SVF coefficient sequencer
// Purpose: on each rising edge of sample_clk, capture the cutoff and resonance
//          control voltages, map them to clamped F / Q1 targets, step the
//          coefficients toward them and publish both with a coeff_valid pulse.
// Build option: define FILTER_CTRL_SLEW_EN to limit each update to SLEW_STEP;
//               without it the clamped targets are loaded directly.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   sample_clk  in   sample strobe, sampled on clk
//   cv_cutoff   in   W signed raw cutoff control voltage
//   cv_reso     in   W signed raw resonance control voltage
//   F           out  W signed cutoff coefficient
//   Q1          out  W signed damping coefficient
//   coeff_valid out  one-clk pulse when F and Q1 update
//   overrun     out  sticky: sample edge arrived while busy
module filter_ctrl_slew
    import filter_ctrl_pkg::*;
#(
    parameter int W         = 16,
    parameter int SLEW_STEP = 64,
    parameter int F_MIN     = -31000,
    parameter int F_MAX     = -1000,
    parameter int Q_MIN     = -32000,
    parameter int Q_MAX     = -8000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] cv_cutoff,
    input  logic signed [W-1:0] cv_reso,
    output logic signed [W-1:0] F,
    output logic signed [W-1:0] Q1,
    output logic                coeff_valid,
    output logic                overrun
);

    localparam int XW = W + 2;
    typedef logic signed [XW-1:0] ext_t;

`ifdef FILTER_CTRL_SLEW_EN
    localparam ext_t STEP_LIM = ext_t'(SLEW_STEP);
`else
    // A step larger than any possible difference makes the limiter a pass-through.
    localparam ext_t STEP_LIM = {1'b0, {(XW-1){1'b1}}};
`endif

    function automatic ext_t clamp_x(input ext_t v, input ext_t lo, input ext_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    state_t              state_q, state_d;
    logic                smp_q, smp_d;
    logic                prev_q, prev_d;
    logic                armed_q, armed_d;
    logic                ovr_q, ovr_d;
    logic signed [W-1:0] f_out_q, f_out_d;
    logic signed [W-1:0] q_out_q, q_out_d;
    logic signed [W-1:0] f_new_q, f_new_d;
    logic signed [W-1:0] f_tgt_q, f_tgt_d;
    logic signed [W-1:0] q_tgt_q, q_tgt_d;

    logic                rise;
    ext_t                cv_c_x, cv_r_x, cut_x, res_x, f_tgt_x, q_tgt_x;
    logic signed [W-1:0] lim_cur, lim_tgt, lim_nxt;

    // One limiter shared by both coefficients; SLEW_Q selects the Q1 pair.
    assign lim_cur = (state_q == SLEW_Q) ? q_out_q : f_out_q;
    assign lim_tgt = (state_q == SLEW_Q) ? q_tgt_q : f_tgt_q;

    slew_limit #(.W(W)) u_slew_limit (
        .cur    (lim_cur),
        .target (lim_tgt),
        .step   (STEP_LIM),
        .nxt    (lim_nxt)
    );

    assign rise = armed_q & smp_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        f_out_d = f_out_q;
        q_out_d = q_out_q;
        f_new_d = f_new_q;
        f_tgt_d = f_tgt_q;
        q_tgt_d = q_tgt_q;

        // The first cycle out of reset loads both history bits from the pin,
        // so a strobe that is already high is not mistaken for an edge.
        armed_d = 1'b1;
        smp_d   = sample_clk;
        prev_d  = armed_q ? smp_q : sample_clk;

        cv_c_x  = {{2{cv_cutoff[W-1]}}, cv_cutoff};
        cv_r_x  = {{2{cv_reso[W-1]}}, cv_reso};
        cut_x   = ((-cv_c_x) >>> 1) + ext_t'(CUT_OFFSET);
        res_x   = ext_t'(RESO_BASE) + (cv_r_x >>> 2);
        f_tgt_x = clamp_x(cut_x, ext_t'(F_MIN), ext_t'(F_MAX));
        q_tgt_x = clamp_x(res_x, ext_t'(Q_MIN), ext_t'(Q_MAX));

        if (rise && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                f_tgt_d = f_tgt_x[W-1:0];
                q_tgt_d = q_tgt_x[W-1:0];
                state_d = SLEW_F;
            end
            SLEW_F: begin
                f_new_d = lim_nxt;
                state_d = SLEW_Q;
            end
            SLEW_Q: begin
                // Both outputs change together on entry to COMMIT.
                f_out_d = f_new_q;
                q_out_d = lim_nxt;
                state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            smp_q   <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            ovr_q   <= 1'b0;
            f_out_q <= W'(F_RESET);
            q_out_q <= W'(Q_RESET);
            f_new_q <= W'(F_RESET);
            f_tgt_q <= W'(F_RESET);
            q_tgt_q <= W'(Q_RESET);
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            ovr_q   <= ovr_d;
            f_out_q <= f_out_d;
            q_out_q <= q_out_d;
            f_new_q <= f_new_d;
            f_tgt_q <= f_tgt_d;
            q_tgt_q <= q_tgt_d;
        end
    end

    assign F           = f_out_q;
    assign Q1          = q_out_q;
    assign coeff_valid = (state_q == COMMIT);
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_filter_ctrl_slew.sv
// tb/tb_filter_ctrl_slew.sv - self-checking bench for filter_ctrl_slew
module tb_filter_ctrl_slew;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_clk = 1'b1;
    logic signed [W-1:0] cv_cutoff = '0;
    logic signed [W-1:0] cv_reso = '0;
    logic signed [W-1:0] F;
    logic signed [W-1:0] Q1;
    logic                coeff_valid;
    logic                overrun;

    typedef struct {
        int f;
        int q;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   pulses = 0;
    int   hold_f = -15000;
    int   hold_q = -32000;
    int   mf = -15000;
    int   mq = -32000;

    always #5 clk = ~clk;

    filter_ctrl_slew dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .cv_cutoff   (cv_cutoff),
        .cv_reso     (cv_reso),
        .F           (F),
        .Q1          (Q1),
        .coeff_valid (coeff_valid),
        .overrun     (overrun)
    );

    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int f_target(input int cv);
        return clampi(floor_div(-cv, 2) - 15000, -31000, -1000);
    endfunction

    function automatic int q_target(input int cv);
        return clampi(floor_div(cv, 4) - 32000, -32000, -8000);
    endfunction

    function automatic int slew(input int cur, input int tgt);
`ifdef FILTER_CTRL_SLEW_EN
        return cur + clampi(tgt - cur, -64, 64);
`else
        return tgt;
`endif
    endfunction

    // Scoreboard consumer: every pulse pops one expectation; between pulses
    // the outputs must hold the last committed values.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            n_checks++;
            if (coeff_valid === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: coeff_valid=1 F=%0d Q1=%0d, required no pulse", F, Q1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (int'(F) !== e.f || int'(Q1) !== e.q) begin
                        n_fail++;
                        $display("FAIL commit_value: F=%0d Q1=%0d, required F=%0d Q1=%0d", F, Q1, e.f, e.q);
                    end
                    hold_f = e.f;
                    hold_q = e.q;
                end
            end else if (int'(F) !== hold_f || int'(Q1) !== hold_q) begin
                n_fail++;
                $display("FAIL hold_value: F=%0d Q1=%0d, required F=%0d Q1=%0d", F, Q1, hold_f, hold_q);
            end
        end
    end

    task automatic clear_model();
        sb.delete();
        mf = -15000;
        mq = -32000;
        hold_f = -15000;
        hold_q = -32000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic issue_edge(input int cc, input int cr, input bit scramble);
        @(negedge clk);
        cv_cutoff  = W'(cc);
        cv_reso    = W'(cr);
        sample_clk = 1'b1;
        mf = slew(mf, f_target(cc));
        mq = slew(mq, q_target(cr));
        sb.push_back('{mf, mq});
        repeat (3) @(negedge clk);
        if (scramble) begin
            cv_cutoff = W'($urandom);
            cv_reso   = W'($urandom);
        end
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int p0;
        rst = 1'b1;
        sample_clk = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (int'(F) !== -15000 || int'(Q1) !== -32000 || coeff_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: F=%0d Q1=%0d cv=%b ov=%b, required -15000 -32000 0 0", F, Q1, coeff_valid, overrun);
        end
        p0 = pulses;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (pulses - p0 !== 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL high_after_reset: pulses=%0d, required 0", pulses - p0);
        end
        sample_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero();
        int p0;
        p0 = pulses;
        for (int i = 0; i < 10; i++) issue_edge(0, 0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (pulses - p0 !== 10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL zero_pulses: got %0d pending %0d, required 10 pending 0", pulses - p0, sb.size());
        end
        n_checks++;
        if (int'(F) !== -15000 || int'(Q1) !== -32000) begin
            n_fail++;
            $display("FAIL zero_value: F=%0d Q1=%0d, required -15000 -32000", F, Q1);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        cv_cutoff  = '0;
        cv_reso    = '0;
        sample_clk = 1'b1;
        mf = slew(mf, f_target(0));
        mq = slew(mq, q_target(0));
        sb.push_back('{mf, mq});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (coeff_valid !== (i == 5)) begin
                n_fail++;
                $display("FAIL latency_n%0d: coeff_valid=%b, required %b", i, coeff_valid, (i == 5));
            end
        end
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cutoff_slew();
        do_reset();
        issue_edge(-20000, 0, 1'b0);
        n_checks++;
`ifdef FILTER_CTRL_SLEW_EN
        if (int'(F) !== -14936) begin
            n_fail++;
            $display("FAIL cutoff_first_step: F=%0d, required -14936", F);
        end
`else
        if (int'(F) !== -5000) begin
            n_fail++;
            $display("FAIL cutoff_first_step: F=%0d, required -5000", F);
        end
`endif
        for (int i = 1; i < 160; i++) issue_edge(-20000, 0, 1'b0);
        n_checks++;
        if (int'(F) !== -5000) begin
            n_fail++;
            $display("FAIL cutoff_settled: F=%0d, required -5000", F);
        end
    endtask

    task automatic test_capture();
        for (int i = 0; i < 4; i++) issue_edge(-20000, 8000, 1'b1);
        cv_cutoff = '0;
        cv_reso   = '0;
    endtask

    task automatic test_cutoff_clamp();
        do_reset();
        for (int i = 0; i < 70; i++) issue_edge(-32768, 0, 1'b0);
        n_checks++;
        if (int'(F) !== -1000) begin
            n_fail++;
            $display("FAIL cutoff_clamp_hi: F=%0d, required -1000", F);
        end
        for (int i = 0; i < 480; i++) issue_edge(32767, 0, 1'b0);
        n_checks++;
        if (int'(F) !== -31000) begin
            n_fail++;
            $display("FAIL cutoff_clamp_lo: F=%0d, required -31000", F);
        end
    endtask

    task automatic test_reso();
        do_reset();
        issue_edge(0, 8000, 1'b0);
        n_checks++;
`ifdef FILTER_CTRL_SLEW_EN
        if (int'(Q1) !== -31936) begin
            n_fail++;
            $display("FAIL reso_first_step: Q1=%0d, required -31936", Q1);
        end
`else
        if (int'(Q1) !== -30000) begin
            n_fail++;
            $display("FAIL reso_first_step: Q1=%0d, required -30000", Q1);
        end
`endif
        do_reset();
        for (int i = 0; i < 5; i++) issue_edge(0, -32768, 1'b0);
        n_checks++;
        if (int'(Q1) !== -32000) begin
            n_fail++;
            $display("FAIL reso_clamp: Q1=%0d, required -32000", Q1);
        end
    endtask

    task automatic test_overrun();
        int p0;
        do_reset();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_initial: overrun=%b, required 0", overrun);
        end
        p0 = pulses;
        @(negedge clk);
        cv_cutoff  = W'(-20000);
        cv_reso    = W'(8000);
        sample_clk = 1'b1;
        mf = slew(mf, f_target(-20000));
        mq = slew(mq, q_target(8000));
        sb.push_back('{mf, mq});
        @(negedge clk);
        sample_clk = 1'b0;
        @(negedge clk);
        sample_clk = 1'b1;
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
        end
        n_checks++;
        if (pulses - p0 !== 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d, required 1", pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int i = 0; i < 3; i++) issue_edge(-20000, 8000, 1'b0);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_held: overrun=%b, required 1", overrun);
        end
        p0 = pulses;
        @(negedge clk);
        sample_clk = 1'b1;
        mf = slew(mf, f_target(-20000));
        mq = slew(mq, q_target(8000));
        sb.push_back('{mf, mq});
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        @(negedge clk);
        n_checks++;
        if (coeff_valid !== 1'b0 || int'(F) !== -15000 || int'(Q1) !== -32000 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: cv=%b F=%0d Q1=%0d ov=%b, required 0 -15000 -32000 0", coeff_valid, F, Q1, overrun);
        end
        sample_clk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (pulses - p0 !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_pulses: got %0d, required 0", pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_latency();
        test_cutoff_slew();
        test_capture();
        test_cutoff_clamp();
        test_reso();
        test_overrun();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: pending=%0d, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
